vga_sync_timing: RTL and testbench

// - Generates 640x480@60 VGA raster timing and drives pix_x/pix_y into the character/graphics

---
 rtl/vga_sync_timing.sv | 152 +++++++++++++++
 tb/tb_vga_sync_timing.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_timing.sv
// 640x480@60 VGA raster timing with pixel-rate divider, CLK-rate sync/blank delay line and pin RGB register.
// Optional build macro VGA_RGB_BLANK_EN forces rgb_out black whenever the delayed video_on is low.
module vga_sync_timing #(
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        p_tick,
  output logic        frame_start,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

  logic [2:0]  div_cnt_q, div_cnt_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        p_tick_q;
  logic        frame_q;
  logic        run_q;
  logic        tick;
  logic        wrap;
  logic        vis_d, hs_d, vs_d;
  logic        rgb_vis;
  logic [11:0] rgb_d, rgb_q;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 3'd1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
    wrap = tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  end

  // p_tick and frame_start are registered on the same edge the counters move.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      p_tick_q  <= 1'b0;
      frame_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      p_tick_q  <= tick;
      frame_q   <= wrap;
      run_q     <= 1'b1;
    end
  end

  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign p_tick      = p_tick_q;
  assign frame_start = frame_q;

  // run_q holds the decode inactive while the counters sit at their reset (0,0),
  // so a zero-delay build still shows reset values on the outputs.
  always_comb begin
    vis_d = run_q && (h_cnt_q < H_VIS_L) && (v_cnt_q < V_VIS_L);
    hs_d  = !(run_q && (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vs_d  = !(run_q && (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
  end

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign video_on = vis_d;
      assign hsync    = hs_d;
      assign vsync    = vs_d;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] vis_pipe_q, hs_pipe_q, vs_pipe_q;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          vis_pipe_q <= '0;
          hs_pipe_q  <= '1;
          vs_pipe_q  <= '1;
        end else begin
          vis_pipe_q[0] <= vis_d;
          hs_pipe_q[0]  <= hs_d;
          vs_pipe_q[0]  <= vs_d;
          for (int unsigned i = 1; i < PIPE_DLY; i++) begin
            vis_pipe_q[i] <= vis_pipe_q[i-1];
            hs_pipe_q[i]  <= hs_pipe_q[i-1];
            vs_pipe_q[i]  <= vs_pipe_q[i-1];
          end
        end
      end

      assign video_on = vis_pipe_q[PIPE_DLY-1];
      assign hsync    = hs_pipe_q[PIPE_DLY-1];
      assign vsync    = vs_pipe_q[PIPE_DLY-1];
    end
  endgenerate

  assign rgb_vis = video_on;

  always_comb begin
`ifdef VGA_RGB_BLANK_EN
    rgb_d = rgb_vis ? rgb_in : '0;
`else
    rgb_d = rgb_in;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_out = rgb_q;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Randomized bench: full-size raster (CLK_DIV=1, PIPE_DLY=2) and a shrunken raster
// (CLK_DIV=4, PIPE_DLY=0) checked every cycle against an arithmetic edge-count model.
module tb_vga_sync_timing;

  localparam int A_D = 1, A_P = 2;
  localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VV = 480, A_VF = 10, A_VS = 2, A_VB = 33;
  localparam int B_D = 4, B_P = 0;
  localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VV = 4, B_VF = 1, B_VS = 2, B_VB = 1;

  logic        CLK = 1'b0;
  logic        rst_a, rst_b;
  logic [11:0] rgb_a, rgb_b;
  logic [9:0]  px_a, py_a, px_b, py_b;
  logic        pt_a, fs_a, vo_a, hs_a, vs_a;
  logic        pt_b, fs_b, vo_b, hs_b, vs_b;
  logic [11:0] ro_a, ro_b;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          ka = 0, kb = 0;
  logic [11:0] exp_ro_a = '0, exp_ro_b = '0;
  bit          fff_mode = 1'b0;
  int          hs_low = 0, fs_gap = 0;

  always #5 CLK = ~CLK;

  vga_sync_timing #(.CLK_DIV(A_D), .PIPE_DLY(A_P)) u_dut_a (
    .CLK(CLK), .RESET(rst_a), .rgb_in(rgb_a), .pix_x(px_a), .pix_y(py_a),
    .p_tick(pt_a), .frame_start(fs_a), .video_on(vo_a), .hsync(hs_a), .vsync(vs_a),
    .rgb_out(ro_a));

  vga_sync_timing #(.CLK_DIV(B_D), .PIPE_DLY(B_P),
                    .H_VIS(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
                    .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)) u_dut_b (
    .CLK(CLK), .RESET(rst_b), .rgb_in(rgb_b), .pix_x(px_b), .pix_y(py_b),
    .p_tick(pt_b), .frame_start(fs_b), .video_on(vo_b), .hsync(hs_b), .vsync(vs_b),
    .rgb_out(ro_b));

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {video_on, hsync, vsync} for the raster position reached after k edges since reset.
  function automatic logic [2:0] dec(int k, int d, int hv, int hf, int hs, int hb,
                                     int vv, int vf, int vs, int vb);
    int ht, vt, p, x, y;
    if (k < 1) return 3'b011;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    p  = k / d;
    x  = p % ht;
    y  = (p / ht) % vt;
    return {(x < hv) && (y < vv), !(x >= hv + hf && x < hv + hf + hs),
            !(y >= vv + vf && y < vv + vf + vs)};
  endfunction

  function automatic logic [11:0] gate(logic [11:0] rgb, logic [2:0] d);
`ifdef VGA_RGB_BLANK_EN
    return d[2] ? rgb : 12'h000;
`else
    return (d[2] || !d[2]) ? rgb : 12'h000;
`endif
  endfunction

  always @(posedge CLK) begin
    exp_ro_a <= rst_a ? 12'h000 :
                gate(rgb_a, dec(ka - A_P, A_D, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB));
    exp_ro_b <= rst_b ? 12'h000 :
                gate(rgb_b, dec(kb - B_P, B_D, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB));
    ka <= rst_a ? 0 : ka + 1;
    kb <= rst_b ? 0 : kb + 1;
  end

  task automatic check_dut(input string nm, input int k, input int d, input int pd,
                           input int hv, input int hf, input int hs, input int hb,
                           input int vv, input int vf, input int vs, input int vb,
                           input logic [9:0] px, input logic [9:0] py,
                           input logic pt, input logic fs, input logic vo,
                           input logic hsy, input logic vsy,
                           input logic [11:0] ro, input logic [11:0] exp_ro);
    int ht, vt, p;
    logic [2:0] e;
    logic tk;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    p  = k / d;
    tk = (k >= 1) && (k % d == 0);
    e  = dec(k - pd, d, hv, hf, hs, hb, vv, vf, vs, vb);
    check_eq({nm, ".pix_x"}, int'(px), p % ht);
    check_eq({nm, ".pix_y"}, int'(py), (p / ht) % vt);
    check_eq({nm, ".p_tick"}, int'(pt), int'(tk));
    check_eq({nm, ".frame_start"}, int'(fs), int'(tk && (p % (ht * vt) == 0)));
    check_eq({nm, ".video_on"}, int'(vo), int'(e[2]));
    check_eq({nm, ".hsync"}, int'(hsy), int'(e[1]));
    check_eq({nm, ".vsync"}, int'(vsy), int'(e[0]));
    check_eq({nm, ".rgb_out"}, int'(ro), int'(exp_ro));
  endtask

  task automatic cycle();
    @(negedge CLK);
    check_dut("A", ka, A_D, A_P, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB,
              px_a, py_a, pt_a, fs_a, vo_a, hs_a, vs_a, ro_a, exp_ro_a);
    check_dut("B", kb, B_D, B_P, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB,
              px_b, py_b, pt_b, fs_b, vo_b, hs_b, vs_b, ro_b, exp_ro_b);
    // Independent pulse-width and frame-period measurements.
    if (ka == 0) hs_low = 0;
    else if (!hs_a) hs_low++;
    else if (hs_low > 0) begin
      check_eq("A.hsync_width", hs_low, A_HS);
      hs_low = 0;
    end
    if (kb == 0) fs_gap = 0;
    else begin
      fs_gap++;
      if (fs_b) begin
        check_eq("B.frame_period", fs_gap,
                 B_D * (B_HV + B_HF + B_HS + B_HB) * (B_VV + B_VF + B_VS + B_VB));
        fs_gap = 0;
      end
    end
    rgb_a = fff_mode ? 12'hFFF : 12'($urandom);
    rgb_b = fff_mode ? 12'hFFF : 12'($urandom);
  endtask

  initial begin
    int tgt_x, tgt_y, n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rgb_a = 12'h000;
    rgb_b = 12'h000;
    repeat (3) cycle();
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int ph = 0; ph < 6; ph++) begin
      fff_mode = (ph % 2 == 0);
      n = $urandom_range(1200, 2000);
      repeat (n) cycle();

      tgt_x = $urandom_range(100, 599);
      for (int i = 0; i < 1000 && int'(px_a) != tgt_x; i++) cycle();
      check_eq("A.wait_x", int'(px_a), tgt_x);
      rst_a = 1'b1;
      cycle();
      rst_a = 1'b0;

      tgt_y = $urandom_range(1, 6);
      for (int i = 0; i < 700 && !(int'(py_b) == tgt_y && int'(px_b) == 3); i++) cycle();
      check_eq("B.wait_y", int'(py_b), tgt_y);
      rst_b = 1'b1;
      repeat ($urandom_range(1, 2)) cycle();
      rst_b = 1'b0;
    end
    repeat (600) cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
